// File: rtl/riscv_load_unit_if.sv
// Load unit bus bundle: execute-side request, data-memory read port, writeback response.
// slave = the load unit, master = the surrounding pipeline/memory.
interface riscv_load_unit_if #(
   parameter int WORD_LENGTH = 32,
   parameter int ADDR_WIDTH  = 32
);
   logic                   req_valid;
   logic                   req_ready;
   logic [ADDR_WIDTH-1:0]  req_addr;
   logic [1:0]             req_mask_sel;
   logic                   req_unsigned;
   logic [4:0]             req_rd;

   logic                   mem_rd_en;
   logic [ADDR_WIDTH-1:0]  mem_addr;
   logic                   mem_rvalid;
   logic [WORD_LENGTH-1:0] mem_rdata;

   logic                   resp_valid;
   logic                   resp_ready;
   logic [WORD_LENGTH-1:0] resp_data;
   logic [4:0]             resp_rd;
   logic                   resp_misaligned;
   logic                   resp_timeout;
   logic                   busy;

   modport slave (
      input  req_valid, req_addr, req_mask_sel, req_unsigned, req_rd,
      input  mem_rvalid, mem_rdata, resp_ready,
      output req_ready, mem_rd_en, mem_addr,
      output resp_valid, resp_data, resp_rd, resp_misaligned, resp_timeout, busy
   );

   modport master (
      output req_valid, req_addr, req_mask_sel, req_unsigned, req_rd,
      output mem_rvalid, mem_rdata, resp_ready,
      input  req_ready, mem_rd_en, mem_addr,
      input  resp_valid, resp_data, resp_rd, resp_misaligned, resp_timeout, busy
   );
endinterface

// File: rtl/riscv_load_unit.sv
// Single-outstanding load unit: word-aligned read, byte/half/word extract with sign/zero extend.
// Latency: request at N, mem_rd_en at N+1, result earliest at N+3 (misaligned fault at N+1); stalls via busy.
module riscv_load_unit #(
   parameter int WORD_LENGTH    = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst,
   riscv_load_unit_if.slave bus
);
   localparam logic [1:0] MASK_B = 2'd0;
   localparam logic [1:0] MASK_H = 2'd1;
   localparam logic [1:0] MASK_X = 2'd2;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [1:0]             sel_q, sel_d;
   logic                   uns_q, uns_d;
   logic [4:0]             rd_q, rd_d;
   logic [WORD_LENGTH-1:0] data_q, data_d;
   logic                   mis_q, mis_d;
   logic                   to_q, to_d;

   logic                   req_mis;
   logic [7:0]             byte_sel;
   logic [15:0]            half_sel;
   logic [WORD_LENGTH-1:0] ext;
   logic                   req_ready, mem_rd_en;

   assign req_mis = ((bus.req_mask_sel == MASK_H) && bus.req_addr[0]) ||
                    ((bus.req_mask_sel == MASK_X) && (bus.req_addr[1:0] != 2'b00));

   // Extraction always works from the latched request, never the live request inputs.
   always_comb begin
      byte_sel = 8'h00;
      case (addr_q[1:0])
         2'd0:    byte_sel = bus.mem_rdata[7:0];
         2'd1:    byte_sel = bus.mem_rdata[15:8];
         2'd2:    byte_sel = bus.mem_rdata[23:16];
         default: byte_sel = bus.mem_rdata[31:24];
      endcase
      half_sel = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (sel_q)
         MASK_B:  ext = {{(WORD_LENGTH-8){~uns_q & byte_sel[7]}}, byte_sel};
         MASK_H:  ext = {{(WORD_LENGTH-16){~uns_q & half_sel[15]}}, half_sel};
         MASK_X:  ext = bus.mem_rdata;
         default: ext = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      sel_d     = sel_q;
      uns_d     = uns_q;
      rd_d      = rd_q;
      data_d    = data_q;
      mis_d     = mis_q;
      to_d      = to_q;
      req_ready = 1'b0;
      mem_rd_en = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid) begin
               addr_d = bus.req_addr;
               sel_d  = bus.req_mask_sel;
               uns_d  = bus.req_unsigned;
               rd_d   = bus.req_rd;
               if (req_mis) begin
                  mis_d   = 1'b1;
                  data_d  = '0;
                  state_d = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            mem_rd_en = 1'b1;
            cnt_d     = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            // Data arriving on the final wait cycle beats the timeout.
            if (bus.mem_rvalid) begin
               data_d  = ext;
               to_d    = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               data_d  = '0;
               to_d    = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            if (bus.resp_ready) begin
               data_d  = '0;
               mis_d   = 1'b0;
               to_d    = 1'b0;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         sel_q   <= '0;
         uns_q   <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
         mis_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         sel_q   <= sel_d;
         uns_q   <= uns_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         mis_q   <= mis_d;
         to_q    <= to_d;
      end
   end

   assign bus.req_ready       = req_ready;
   assign bus.mem_rd_en       = mem_rd_en;
   assign bus.mem_addr        = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign bus.resp_valid      = (state_q == RESP);
   assign bus.resp_data       = data_q;
   assign bus.resp_rd         = rd_q;
   assign bus.resp_misaligned = mis_q;
   assign bus.resp_timeout    = to_q;
   assign bus.busy            = (state_q != IDLE);
endmodule
